// File: rtl/vc_fifo_bank.sv
// Four independent per-VC FIFOs sharing one push port and one pop port, with
// registered status, hysteretic pause/continue strobes and sticky error flags.
module vc_fifo_bank #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AFULL  = 6,
  parameter int unsigned AEMPTY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [1:0]        push_vc,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [1:0]        pop_vc,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [3:0]        empty,
  output logic [3:0]        full,
  output logic [3:0]        stb_pause,
  output logic [3:0]        stb_continue,
  output logic [3:0]        err_overflow,
  output logic [3:0]        err_underflow
);

  localparam int unsigned NumVc = 4;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [CntW-1:0] CntMax    = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAfull  = CntW'(AFULL);
  localparam logic [CntW-1:0] CntAempty = CntW'(AEMPTY);

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StPaused = 1'b1;

  logic [DATA_W-1:0] mem_q    [NumVc][DEPTH];
  logic [PtrW-1:0]   wr_ptr_q [NumVc];
  logic [PtrW-1:0]   wr_ptr_d [NumVc];
  logic [PtrW-1:0]   rd_ptr_q [NumVc];
  logic [PtrW-1:0]   rd_ptr_d [NumVc];
  logic [CntW-1:0]   count_q  [NumVc];
  logic [CntW-1:0]   count_d  [NumVc];
  logic [0:0]        state_q  [NumVc];
  logic [0:0]        state_d  [NumVc];

  logic [NumVc-1:0] push_hit, pop_hit, pause_d, cont_d, empty_d, full_d;
  logic             pop_legal, push_ok;

  always_comb begin
    // Legality is judged on pre-edge counts; a pop into an empty VC never bypasses a push.
    pop_legal = pop && (count_q[pop_vc] != '0);
    push_ok   = push && ((count_q[push_vc] != CntMax) || (pop_legal && (pop_vc == push_vc)));

    push_hit = '0;
    pop_hit  = '0;
    pause_d  = '0;
    cont_d   = '0;
    empty_d  = '0;
    full_d   = '0;
    for (int i = 0; i < NumVc; i++) begin
      push_hit[i] = push_ok && (push_vc == 2'(i));
      pop_hit[i]  = pop_legal && (pop_vc == 2'(i));
      wr_ptr_d[i] = push_hit[i] ? wr_ptr_q[i] + PtrW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_hit[i] ? rd_ptr_q[i] + PtrW'(1) : rd_ptr_q[i];
      count_d[i]  = count_q[i] + CntW'(push_hit[i]) - CntW'(pop_hit[i]);
      empty_d[i]  = (count_d[i] == '0);
      full_d[i]   = (count_d[i] == CntMax);

      state_d[i] = state_q[i];
      if ((state_q[i] == StRun) && (count_d[i] >= CntAfull)) begin
        state_d[i] = StPaused;
        pause_d[i] = 1'b1;
      end else if ((state_q[i] == StPaused) && (count_d[i] <= CntAempty)) begin
        state_d[i] = StRun;
        cont_d[i]  = 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[push_vc][wr_ptr_q[push_vc]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NumVc; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        state_q[i]  <= StRun;
      end
      pop_data      <= '0;
      pop_valid     <= 1'b0;
      empty         <= 4'hF;
      full          <= '0;
      stb_pause     <= '0;
      stb_continue  <= '0;
      err_overflow  <= '0;
      err_underflow <= '0;
    end else begin
      for (int i = 0; i < NumVc; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
        state_q[i]  <= state_d[i];
      end
      pop_valid <= pop_legal;
      if (pop_legal) begin
        pop_data <= mem_q[pop_vc][rd_ptr_q[pop_vc]];
      end
      empty        <= empty_d;
      full         <= full_d;
      stb_pause    <= pause_d;
      stb_continue <= cont_d;
      if (push && !push_ok) begin
        err_overflow[push_vc] <= 1'b1;
      end
      if (pop && !pop_legal) begin
        err_underflow[pop_vc] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Scoreboard bench for vc_fifo_bank: a queue-based model predicts status and popped words,
// a negedge monitor compares them against the DUT.
module tb_vc_fifo_bank;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AFULL  = 6;
  localparam int unsigned AEMPTY = 2;

  typedef logic [DATA_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              push = 1'b0;
  logic [1:0]        push_vc = '0;
  logic [DATA_W-1:0] push_data = '0;
  logic              pop = 1'b0;
  logic [1:0]        pop_vc = '0;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [3:0]        empty, full, stb_pause, stb_continue, err_overflow, err_underflow;

  vc_fifo_bank #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AFULL (AFULL),
    .AEMPTY(AEMPTY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_vc      (push_vc),
    .push_data    (push_data),
    .pop          (pop),
    .pop_vc       (pop_vc),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .empty        (empty),
    .full         (full),
    .stb_pause    (stb_pause),
    .stb_continue (stb_continue),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  word_t     mq [4][$];
  word_t     sb [$];
  bit  [3:0] m_paused, m_sp, m_sc, m_of, m_uf;
  bit        m_pv;
  word_t     m_pd;

  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;

  function automatic void model_step(input bit rst, input bit ps, input logic [1:0] pv,
                                     input word_t pd, input bit pp, input logic [1:0] ppv);
    bit legal, acc;
    int n;
    if (!rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_paused = '0; m_sp = '0; m_sc = '0; m_of = '0; m_uf = '0;
      m_pv = 1'b0; m_pd = '0;
      return;
    end
    legal = pp && (mq[ppv].size() > 0);
    acc   = ps && ((mq[pv].size() < DEPTH) || (legal && ppv == pv));
    m_pv  = legal;
    if (legal) begin
      m_pd = mq[ppv].pop_front();
      sb.push_back(m_pd);
    end
    if (pp && !legal) m_uf[ppv] = 1'b1;
    if (ps && !acc) m_of[pv] = 1'b1;
    if (acc) mq[pv].push_back(pd);
    for (int i = 0; i < 4; i++) begin
      n = mq[i].size();
      m_sp[i] = !m_paused[i] && (n >= AFULL);
      m_sc[i] = m_paused[i] && (n <= AEMPTY);
      if (m_sp[i]) m_paused[i] = 1'b1;
      if (m_sc[i]) m_paused[i] = 1'b0;
    end
  endfunction

  task automatic step(input bit rst, input bit ps, input logic [1:0] pv, input word_t pd,
                      input bit pp, input logic [1:0] ppv);
    reset = rst; push = ps; push_vc = pv; push_data = pd; pop = pp; pop_vc = ppv;
    @(posedge clk);
    model_step(rst, ps, pv, pd, pp, ppv);
    mon_en = 1'b1;
    #1;
  endtask

  task automatic do_push(input logic [1:0] vc, input word_t d);
    step(1'b1, 1'b1, vc, d, 1'b0, 2'd0);
  endtask

  task automatic do_pop(input logic [1:0] vc);
    step(1'b1, 1'b0, 2'd0, '0, 1'b1, vc);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  function automatic logic [3:0] exp_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  function automatic logic [3:0] exp_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  // Monitor: status every cycle, popped words against the scoreboard when pop_valid is high.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [28:0] act, expv;
      act  = {empty, full, stb_pause, stb_continue, err_overflow, err_underflow, pop_valid,
              pop_data};
      expv = {exp_empty(), exp_full(), m_sp, m_sc, m_of, m_uf, m_pv, m_pd};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL status t=%0t got e=%b f=%b sp=%b sc=%b of=%b uf=%b v=%b d=%h want e=%b f=%b sp=%b sc=%b of=%b uf=%b v=%b d=%h",
                 $time, empty, full, stb_pause, stb_continue, err_overflow, err_underflow,
                 pop_valid, pop_data, exp_empty(), exp_full(), m_sp, m_sc, m_of, m_uf, m_pv,
                 m_pd);
      end
      if (pop_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_word t=%0t got %h want no word pending", $time, pop_data);
        end else begin
          word_t w;
          w = sb.pop_front();
          if (pop_data !== w) begin
            errors++;
            $display("FAIL pop_word t=%0t got %h want %h", $time, pop_data, w);
          end
        end
      end
    end
  end

  initial begin
    // T1: reset held with push and pop active
    repeat (3) step(1'b0, 1'b1, 2'd1, 4'h5, 1'b1, 2'd1);
    idle();
    // T2: FIFO order on VC2
    for (int i = 1; i <= 3; i++) do_push(2'd2, word_t'(i));
    repeat (3) do_pop(2'd2);
    idle();
    // T3: pause at 6, continue at 2
    for (int i = 0; i < 6; i++) do_push(2'd0, word_t'(i + 8));
    repeat (4) do_pop(2'd0);
    repeat (2) do_pop(2'd0);
    idle();
    // T4: overflow on VC1, then drain
    for (int i = 1; i <= 9; i++) do_push(2'd1, word_t'(i));
    repeat (8) do_pop(2'd1);
    idle();
    // T5: simultaneous push/pop on full VC3 and on empty VC1
    for (int i = 0; i < 8; i++) do_push(2'd3, word_t'(i + 3));
    step(1'b1, 1'b1, 2'd3, 4'hE, 1'b1, 2'd3);
    step(1'b1, 1'b1, 2'd1, 4'h7, 1'b1, 2'd1);
    do_pop(2'd1);
    repeat (8) do_pop(2'd3);
    idle();
    // T6: pointer wrap with interleaving, then reset while VC0 holds 5 words
    for (int i = 0; i < 20; i++) begin
      do_push(2'd0, word_t'(i));
      if (i % 3 != 0) do_pop(2'd0);
    end
    while (mq[0].size() > 5) do_pop(2'd0);
    while (mq[0].size() < 5) do_push(2'd0, 4'hA);
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 2'd0);
    do_pop(2'd0);
    idle();
    // Random: push-heavy then pop-heavy phases, with rare resets
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit r, ps, pp;
        r  = ($urandom_range(0, 99) != 0);
        ps = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 80 : 30));
        pp = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 80));
        step(r, ps, 2'($urandom_range(0, 3)), word_t'($urandom_range(0, 15)), pp,
             2'($urandom_range(0, 3)));
      end
    end
    idle();
    idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending words want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
